// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_pkg: APB state encoding and default bus widths shared by the     |
// | requester and the completer.                  Revision: 1.0           |
// +----------------------------------------------------------------------+
package apb_pkg;

  localparam int c_addr_w = 5;
  localparam int c_data_w = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master: valid/ready command to APB SETUP/ACCESS requester with   |
// | bounded PREADY wait.                          Revision: 1.0           |
// +----------------------------------------------------------------------+
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = c_addr_w,
  parameter int DATA_W  = c_data_w,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  // Last ACCESS cycle index before the transfer is abandoned.
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

  apb_state_e r_state;
  apb_state_e w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic       w_accept;
  logic       w_done;
  logic       w_abort;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: begin
        // pready takes priority over a timeout landing on the same edge
        if (pready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_wait_cnt == c_wait_last) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 8'd0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      psel       <= (w_state_nxt != IDLE);
      penable    <= (w_state_nxt == ACCESS);
      r_wait_cnt <= (r_state == ACCESS && w_state_nxt == ACCESS) ? r_wait_cnt + 8'd1 : 8'd0;
      rsp_valid  <= w_done | w_abort;
      if (w_accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      if (w_done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (w_abort) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers toward one APB completer.
- Returns read data and a completion/error response to the local requester.
- Sits between the local controller logic and the APB slave, using the same 5-bit address and 32-bit data widths as the slave.
- One transfer in flight at a time, with a bounded wait for PREADY.

Parameters:
- ADDR_W, 5, APB address width (paddr / cmd_addr).
- DATA_W, 32, APB data width (pwdata, prdata, cmd_wdata, rsp_rdata).
- TIMEOUT, 16, max ACCESS cycles waiting for pready before abort; legal range 1..255.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  requester has a command.
- cmd_ready  output  1  block can accept a command (IDLE only).
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  timeout flag, valid with rsp_valid.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_W  APB address.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  APB read data.
- pready  input  1  APB completer ready.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err = 0.
  - paddr, pwdata, rsp_rdata = 0.
  - wait counter = 0.
  - cmd_ready = 1 after reset.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On a posedge with cmd_valid=1, latch cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0, cmd_ready=0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - psel=1, penable=1, and paddr/pwrite/pwdata held stable.
  - pready sampled at each posedge.
  - If pready=1: complete.
    - rsp_valid=1 next cycle.
    - rsp_rdata = prdata for reads, 0 for writes.
    - rsp_err=0.
    - Return to IDLE.
  - Otherwise increment the wait counter.
  - When the counter reaches TIMEOUT-1 with pready still 0: abort.
    - rsp_valid=1, rsp_err=1, rsp_rdata=0.
    - Return to IDLE.
- On leaving ACCESS:
  - psel and penable drop to 0 in the same cycle rsp_valid rises.
  - The wait counter clears.
  - paddr/pwdata/pwrite hold their last values until the next command.
- Latency: accept at edge 0; SETUP in cycle 1; ACCESS in cycle 2. With zero wait states, rsp_valid is high in cycle 3. Each wait state adds 1 cycle.
- Throughput: a new command can be accepted in the rsp_valid cycle (state is IDLE). Minimum spacing is 3 cycles per transfer.
- cmd_valid asserted while busy is ignored. The requester holds it until cmd_ready; no queuing.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata and rsp_err hold until the next completion.
- pready asserted in IDLE or SETUP is ignored.
- pready and timeout in the same cycle: pready wins, rsp_err=0.
- prdata is sampled only on the completing ACCESS edge.
- Reset mid-transfer: psel/penable drop immediately (asynchronously), no rsp_valid is produced, and the FSM returns to IDLE.

Decomposition:
- Shared package apb_pkg:
  - state typedef/localparams IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, shared with the slave.
  - default ADDR_W/DATA_W constants.
- No sub-module. The wait counter is inline (8-bit, width fixed by the TIMEOUT range).

Test Plan:
- Write, zero wait: cmd write addr=0x0A data=0xDEADBEEF, pready=1 throughout.
  - -> psel high cycles 1-2, penable high cycle 2, paddr=0x0A, pwdata=0xDEADBEEF.
  - -> rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
- Read with 4 wait states: cmd read addr=0x0A, pready low for 4 ACCESS cycles then high, prdata=0xDEADBEEF.
  - -> penable high 5 cycles.
  - -> rsp_valid cycle 7, rsp_rdata=0xDEADBEEF.
- Timeout: TIMEOUT=16, pready tied 0.
  - -> ACCESS lasts 16 cycles.
  - -> rsp_valid=1, rsp_err=1, rsp_rdata=0; psel=0 the same cycle.
- Busy/back-to-back: cmd_valid held high with two commands (write 0x01=0x1, read 0x01).
  - -> cmd_ready low in SETUP/ACCESS.
  - -> second command accepted in the first rsp_valid cycle.
  - -> read returns 0x00000001 with a 3-cycle spacing.
- Reset mid-ACCESS: assert rst_n=0 while psel=penable=1.
  - -> psel/penable/rsp_valid = 0 immediately.
  - -> after release, cmd_ready=1 and no spurious rsp_valid.
- Early/late pready: pready=1 during SETUP only, then 0.
  - -> not treated as completion; ACCESS continues.
  - -> pready and timeout in the same cycle completes with rsp_err=0.
